// File: rtl/mash111_ddsm_pkg.sv
// Shared constants for the MASH 1-1-1 delta-sigma modulator.
package mash111_ddsm_pkg;

    localparam int DDSM_FRAC_W      = 24;
    localparam int DDSM_OUT_W       = 4;
    localparam int DDSM_PHASE_W     = 12;
    localparam int DDSM_PHASE_SHIFT = 12;
    // Output range is -3..+5, so five bits hold the raw noise-shaped sum.
    localparam int DDSM_SUM_W       = 5;

endpackage

// File: rtl/dsm_acc_stage.sv
// One MASH accumulator stage: acc + a + b, combinational sum/carry out for chaining.
// Accumulator updates on the rising edge only while i_en is high, otherwise it holds.
module dsm_acc_stage
    import mash111_ddsm_pkg::*;
#(
    parameter int W  = DDSM_FRAC_W,
    parameter int CW = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    output logic [W-1:0]  o_sum,
    output logic [CW-1:0] o_carry
);

    logic [W-1:0]    acc_q;
    logic [W-1:0]    acc_d;
    logic [W+CW-1:0] sum_full;

    always_comb begin
        sum_full = (W+CW)'(acc_q) + (W+CW)'(i_a) + (W+CW)'(i_b);
        acc_d    = i_en ? sum_full[W-1:0] : acc_q;
    end

    assign o_sum   = sum_full[W-1:0];
    assign o_carry = sum_full[W+CW-1:W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mash111_ddsm.sv
// MASH 1-1-1 fractional-N modulator with one-shot phase offset injection.
// One step per enabled cycle; o_dsm registered one cycle after the step and held while disabled.
module mash111_ddsm
    import mash111_ddsm_pkg::*;
#(
    parameter int FRAC_W = DDSM_FRAC_W,
    parameter int OUT_W  = DDSM_OUT_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic [7:0]               i_msb,
    input  logic [7:0]               i_isb,
    input  logic [7:0]               i_lsb,
    input  logic [DDSM_PHASE_W-1:0]  i_phaseadd,
    input  logic                     i_phaseadjusten,
    output logic signed [OUT_W-1:0]  o_dsm,
    output logic                     o_valid
);

    logic [FRAC_W-1:0] frac;
    logic [FRAC_W-1:0] phase_off;
    logic [FRAC_W-1:0] s1;
    logic [FRAC_W-1:0] s2;
    logic [FRAC_W-1:0] s3_unused;
    logic [1:0]        c1;
    logic              c2;
    logic              c3;

    logic adj_q, adj_d;
    logic pend_q, pend_d;
    logic adj_edge;
    logic c2_dly_q, c2_dly_d;
    logic c3_dly_q, c3_dly_d;
    logic c3_dly2_q, c3_dly2_d;
    logic signed [OUT_W-1:0]      dsm_q, dsm_d;
    logic                         vld_q, vld_d;
    logic signed [DDSM_SUM_W-1:0] dsm_sum;

    assign frac = FRAC_W'({i_msb, i_isb, i_lsb});

    always_comb begin
        adj_d    = i_phaseadjusten;
        adj_edge = i_phaseadjusten & ~adj_q;
        // A pending request absorbs further edges; it is consumed by the next enabled step.
        pend_d    = i_en ? 1'b0 : (pend_q | adj_edge);
        phase_off = (pend_q | adj_edge)
                  ? FRAC_W'({i_phaseadd, {DDSM_PHASE_SHIFT{1'b0}}}) : '0;

        c2_dly_d  = i_en ? c2       : c2_dly_q;
        c3_dly_d  = i_en ? c3       : c3_dly_q;
        c3_dly2_d = i_en ? c3_dly_q : c3_dly2_q;

        // Modulo-32 arithmetic; the true result always lies in -3..+5.
        dsm_sum = DDSM_SUM_W'(c1)
                + DDSM_SUM_W'(c2) - DDSM_SUM_W'(c2_dly_q)
                + DDSM_SUM_W'(c3) - (DDSM_SUM_W'(c3_dly_q) << 1) + DDSM_SUM_W'(c3_dly2_q);
        dsm_d = i_en ? OUT_W'(dsm_sum) : dsm_q;
        vld_d = i_en;
    end

    dsm_acc_stage #(.W(FRAC_W), .CW(2)) u_stage1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_a     (frac),
        .i_b     (phase_off),
        .o_sum   (s1),
        .o_carry (c1)
    );

    dsm_acc_stage #(.W(FRAC_W), .CW(1)) u_stage2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_a     (s1),
        .i_b     ('0),
        .o_sum   (s2),
        .o_carry (c2)
    );

    dsm_acc_stage #(.W(FRAC_W), .CW(1)) u_stage3 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_a     (s2),
        .i_b     ('0),
        .o_sum   (s3_unused),
        .o_carry (c3)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            adj_q     <= 1'b0;
            pend_q    <= 1'b0;
            c2_dly_q  <= 1'b0;
            c3_dly_q  <= 1'b0;
            c3_dly2_q <= 1'b0;
            dsm_q     <= '0;
            vld_q     <= 1'b0;
        end else begin
            adj_q     <= adj_d;
            pend_q    <= pend_d;
            c2_dly_q  <= c2_dly_d;
            c3_dly_q  <= c3_dly_d;
            c3_dly2_q <= c3_dly2_d;
            dsm_q     <= dsm_d;
            vld_q     <= vld_d;
        end
    end

    assign o_dsm   = dsm_q;
    assign o_valid = vld_q;

endmodule

// File: tb/tb_mash111_ddsm.sv
// Bench for mash111_ddsm: reference model feeding a scoreboard, a vector table for
// enable/phase-adjust interaction, and directed sequences for averages and reset.
module tb_mash111_ddsm;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_en;
    logic [7:0]        i_msb, i_isb, i_lsb;
    logic [11:0]       i_phaseadd;
    logic              i_phaseadjusten;
    logic signed [3:0] o_dsm;
    logic              o_valid;

    mash111_ddsm #(.FRAC_W(24), .OUT_W(4)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_en            (i_en),
        .i_msb           (i_msb),
        .i_isb           (i_isb),
        .i_lsb           (i_lsb),
        .i_phaseadd      (i_phaseadd),
        .i_phaseadjusten (i_phaseadjusten),
        .o_dsm           (o_dsm),
        .o_valid         (o_valid)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int dsm;
        bit vld;
    } exp_t;

    typedef struct {
        bit en;
        bit padj;
        int exp_dsm;
        bit exp_vld;
        int exp_acc1;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_dsm;

    longint m_acc1, m_acc2, m_acc3;
    int     m_c2d, m_c3d, m_c3dd, m_dsm;
    bit     m_pend, m_adjq;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
        m_c2d = 0; m_c3d = 0; m_c3dd = 0; m_dsm = 0;
        m_pend = 0; m_adjq = 0;
    endtask

    // Apply inputs for the coming edge and push the model's prediction.
    task automatic drive(input bit en, input int f, input int padd, input bit padj);
        exp_t   e;
        bit     rise;
        longint s1, s2, s3, p;
        int     c1, c2, c3;
        i_en = en;
        {i_msb, i_isb, i_lsb} = f[23:0];
        i_phaseadd = padd[11:0];
        i_phaseadjusten = padj;
        rise = padj && !m_adjq;
        m_adjq = padj;
        if (en) begin
            p  = (m_pend || rise) ? longint'(padd) * 4096 : 0;
            s1 = m_acc1 + longint'(f) + p;
            c1 = int'(s1 / 16777216);
            m_acc1 = s1 % 16777216;
            s2 = m_acc2 + m_acc1;
            c2 = int'(s2 / 16777216);
            m_acc2 = s2 % 16777216;
            s3 = m_acc3 + m_acc2;
            c3 = int'(s3 / 16777216);
            m_acc3 = s3 % 16777216;
            m_dsm  = c1 + (c2 - m_c2d) + (c3 - 2 * m_c3d + m_c3dd);
            m_c3dd = m_c3d;
            m_c3d  = c3;
            m_c2d  = c2;
            m_pend = 0;
        end else if (rise) begin
            m_pend = 1;
        end
        e.dsm = m_dsm;
        e.vld = en;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        int   act;
        @(posedge i_clk);
        #1;
        act = int'(o_dsm);
        last_dsm = act;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: output seen with no prediction queued");
        end else begin
            e = sb_q.pop_front();
            chk("sb_dsm", act, e.dsm);
            chk("sb_valid", o_valid, e.vld);
        end
        chk("dsm_in_range", (act >= -3 && act <= 5) ? 1 : 0, 1);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_en = 1'b0;
        i_phaseadjusten = 1'b0;
        m_reset();
        sb_q.delete();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        vec_t vt[12];
        int   vals[64];
        int   sum;

        // F=0, i_phaseadd=0x800; edge while disabled, second edge ignored, held output.
        vt[0]  = '{0, 0,  0, 0, 0};
        vt[1]  = '{0, 1,  0, 0, 0};
        vt[2]  = '{0, 0,  0, 0, 0};
        vt[3]  = '{0, 1,  0, 0, 0};
        vt[4]  = '{1, 1,  0, 1, 'h800000};
        vt[5]  = '{1, 0,  1, 1, 'h800000};
        vt[6]  = '{0, 0,  1, 0, 'h800000};
        vt[7]  = '{0, 0,  1, 0, 'h800000};
        vt[8]  = '{1, 0,  0, 1, 'h800000};
        vt[9]  = '{1, 0, -1, 1, 'h800000};
        vt[10] = '{1, 0,  0, 1, 'h800000};
        vt[11] = '{1, 0,  1, 1, 'h800000};

        i_rst_n = 1'b0;
        i_en = 1'b0;
        {i_msb, i_isb, i_lsb} = 24'h0;
        i_phaseadd = 12'h0;
        i_phaseadjusten = 1'b0;
        m_reset();
        #2;
        chk("reset_dsm", int'(o_dsm), 0);
        chk("reset_valid", o_valid, 0);
        chk("reset_acc1", dut.u_stage1.acc_q, 0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        for (int i = 0; i < 64; i++) begin
            drive(1, 0, 0, 0);
            tick();
            chk("zero_input_dsm", last_dsm, 0);
        end

        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].en, 0, 'h800, vt[i].padj);
            tick();
            chk($sformatf("vec%0d_dsm", i), last_dsm, vt[i].exp_dsm);
            chk($sformatf("vec%0d_valid", i), o_valid, vt[i].exp_vld);
            chk($sformatf("vec%0d_acc1", i), dut.u_stage1.acc_q, vt[i].exp_acc1);
        end

        do_reset();
        repeat (2) begin
            drive(1, 0, 'h800, 0);
            tick();
        end
        drive(1, 0, 'h800, 1);
        tick();
        chk("adjust_acc1", dut.u_stage1.acc_q, 'h800000);
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 'h800, (i < 4) ? 1'b1 : 1'b0);
            tick();
            chk("adjust_acc1_hold", dut.u_stage1.acc_q, 'h800000);
        end

        do_reset();
        repeat (3) begin
            drive(1, 'h800000, 0, 0);
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            drive(1, 'h800000, 0, 0);
            tick();
            vals[i] = last_dsm;
        end
        for (int s = 0; s <= 16; s++) begin
            sum = 0;
            for (int k = 0; k < 16; k++) sum += vals[s + k];
            chk($sformatf("half_sum16_at%0d", s), sum, 8);
        end

        do_reset();
        repeat (3) begin
            drive(1, 'h400000, 0, 0);
            tick();
        end
        sum = 0;
        for (int i = 0; i < 64; i++) begin
            drive(1, 'h400000, 0, 0);
            tick();
            sum += last_dsm;
        end
        chk("quarter_sum64", sum, 16);

        do_reset();
        repeat (4) begin
            drive(1, 'hFFFFFF, 'hFFF, 0);
            tick();
        end
        drive(1, 'hFFFFFF, 'hFFF, 1);
        #2;
        chk("c1_on_adjust", dut.c1, 2);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 'hFFFFFF, 'hFFF, 0);
            tick();
        end
        drive(0, 'hFFFFFF, 'hFFF, 0);
        tick();
        drive(0, 'hFFFFFF, 'hFFF, 1);
        tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_dsm", int'(o_dsm), 0);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_acc1", dut.u_stage1.acc_q, 0);
        m_reset();
        sb_q.delete();
        @(posedge i_clk);
        #1;
        i_phaseadjusten = 1'b0;
        i_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 'hFFF, 0);
            tick();
            chk("post_reset_dsm", last_dsm, 0);
            chk("post_reset_acc1", dut.u_stage1.acc_q, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mash111_ddsm.md
MASH111_DDSM -- requirements
Module: mash111_ddsm

Interface
REQ-001 SHALL have parameter FRAC_W, default 24, fractional word width, fixed as {msb,isb,lsb}.
REQ-002 SHALL have parameter OUT_W, default 4, signed output width.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_en  input  1  step enable; one modulator step per cycle while high.
REQ-006 SHALL have port i_msb  input  8  fractional word bits [23:16].
REQ-007 SHALL have port i_isb  input  8  fractional word bits [15:8].
REQ-008 SHALL have port i_lsb  input  8  fractional word bits [7:0].
REQ-009 SHALL have port i_phaseadd  input  12  phase offset, applied at weight 2^12 (F-scale offset = {i_phaseadd,12'b0}).
REQ-010 SHALL have port i_phaseadjusten  input  1  phase-adjust request, level signal; action on rising edge.
REQ-011 SHALL have port o_dsm  output  OUT_W  signed two's-complement divider-modulus offset.
REQ-012 SHALL have port o_valid  output  1  high when o_dsm holds the result of a step.

Function
REQ-013 SHALL form F = {i_msb,i_isb,i_lsb}, sampled on every enabled cycle; no internal holding register for F.
REQ-014 SHALL detect a rising edge of i_phaseadjusten via a registered copy and set a pending flag; the flag clears on the enabled step that consumes it.
REQ-015 SHALL, on an enabled step, form P = {i_phaseadd,12'b0} if pending (or an edge is detected that same cycle), else P = 0.
REQ-016 SHALL compute stage 1: s1 = acc1 + F + P (26-bit); acc1 <= s1[23:0]; c1 = s1[25:24] (0..2).
REQ-017 SHALL compute stage 2: s2 = acc2 + s1[23:0]; acc2 <= s2[23:0]; c2 = s2[24].
REQ-018 SHALL compute stage 3: s3 = acc3 + s2[23:0]; acc3 <= s3[23:0]; c3 = s3[24]; all three stages update in the same cycle (combinational chain).
REQ-019 SHALL keep history registers c2_d, c3_d, c3_dd updated only on enabled steps.
REQ-020 SHALL register o_dsm <= c1 + (c2 - c2_d) + (c3 - 2*c3_d + c3_dd); range -3..+5; latency 1 cycle from the enabled step.
REQ-021 SHALL register o_valid <= i_en; o_dsm holds its value while i_en low.
REQ-022 SHALL freeze accumulators, history and pending flag when i_en low; a rising edge during i_en low sets pending and is applied at the next enabled step.
REQ-023 SHALL ignore further rising edges while pending is set (no accumulation of multiple offsets).
REQ-024 SHALL wrap all accumulators modulo 2^24 with no saturation.

Reset
REQ-025 SHALL asynchronously clear acc1..acc3, c2_d, c3_d, c3_dd, pending flag, edge register, o_dsm (0) and o_valid (0) when i_rst_n low.
REQ-026 SHALL resume from the all-zero state on the first enabled cycle after deassertion; reset mid-operation discards pending adjust.

Structure
REQ-027 SHALL place FRAC_W, OUT_W and the phase-offset shift (12) in the shared DDSM package.
REQ-028 SHALL implement each stage as one sub-module, dsm_acc_stage (adder, 24-bit accumulator, carry out, enable), instantiated three times.

Verification
REQ-029 SHALL test F=0x000000, i_en=1, 64 cycles -> o_dsm = 0 every cycle, o_valid = 1 from cycle 2.
REQ-030 SHALL test F=0x800000 -> after 3-cycle settle, sum of o_dsm over any 16 consecutive steps = 8, all values within -3..+5.
REQ-031 SHALL test F=0x400000 -> sum of o_dsm over 64 consecutive steps = 16.
REQ-032 SHALL test F=0, single i_phaseadjusten rise with i_phaseadd=0x800 -> acc1 = 0x800000 after that step, no further change; second rise while pending ignored (acc1 unchanged by it).
REQ-033 SHALL test i_en=0 when the adjust edge arrives, i_en=1 three cycles later -> offset applied exactly on that first enabled step; o_dsm/acc frozen meanwhile.
REQ-034 SHALL test F=0xFFFFFF, i_phaseadd=0xFFF, with i_rst_n pulsed low mid-run -> c1 = 2 observed on the adjust step, o_dsm never outside -3..+5; after reset all outputs 0 and F=0 gives o_dsm = 0.
